// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbitration of ALU/LSU writebacks onto the single
//            register-file write port, plus a busy scoreboard for RAW stalls.
//            Define REGFILE_WB_ARB_FWD_EN for same-cycle write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter  int N  = 32,
  parameter  int W  = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [W-1:0]  alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [W-1:0]  lsu_data,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata,
  output logic [N-1:0]  busy,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [W-1:0]  rf_rdata1,
  input  logic [W-1:0]  rf_rdata2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e          last_grant_q, last_grant_d;
  logic          grant_alu, grant_lsu;
  logic          xfer;
  logic [AW-1:0] win_rd;
  logic [W-1:0]  win_data;

  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic [N-1:0]  busy_q, busy_d;

  // Arbitration: a tie goes to the source that did not win the previous tie.
  always_comb begin
    grant_alu    = 1'b0;
    grant_lsu    = 1'b0;
    last_grant_d = last_grant_q;
    if (alu_valid && lsu_valid) begin
      if (last_grant_q == SRC_LSU) begin
        grant_alu    = 1'b1;
        last_grant_d = SRC_ALU;
      end else begin
        grant_lsu    = 1'b1;
        last_grant_d = SRC_LSU;
      end
    end else begin
      grant_alu = alu_valid;
      grant_lsu = lsu_valid;
    end
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;
  assign xfer      = grant_alu || grant_lsu;
  assign win_rd    = grant_alu ? alu_rd   : lsu_rd;
  assign win_data  = grant_alu ? alu_data : lsu_data;

  // Writes to x0 are accepted but never raise the write enable.
  always_comb begin
    wen_d   = xfer && (win_rd != '0);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      waddr_d = win_rd;
      wdata_d = win_data;
    end
  end

  // Issue is applied after the commit clear so a same-cycle re-issue stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_LSU;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy     = busy_q;

`ifdef REGFILE_WB_ARB_FWD_EN
  assign rdata1 = (wen_q && (waddr_q == raddr1) && (raddr1 != '0)) ? wdata_q : rf_rdata1;
  assign rdata2 = (wen_q && (waddr_q == raddr2) && (raddr2 != '0)) ? wdata_q : rf_rdata2;
`else
  // Read addresses only matter to the register file itself without bypass.
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign rdata1       = rf_rdata1;
  assign rdata2       = rf_rdata2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Randomized + directed bench for regfile_wb_arbiter against a
//            behavioural model of arbitration, commit, scoreboard and reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = $clog2(N);

  logic          clk;
  logic          rst_n;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [W-1:0]  alu_data;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [W-1:0]  lsu_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;
  logic [N-1:0]  busy;
  logic [AW-1:0] raddr1, raddr2;
  logic [W-1:0]  rf_rdata1, rf_rdata2;
  logic [W-1:0]  rdata1, rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(N), .W(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rdata1    (rdata1),
    .rdata2    (rdata2)
  );

  // Register file environment, written by whatever the DUT commits.
  logic [W-1:0] rf_mem [N];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) rf_mem[i] <= '0;
    end else if (rf_wen) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata1 = (raddr1 == '0) ? '0 : rf_mem[raddr1];
  assign rf_rdata2 = (raddr2 == '0) ? '0 : rf_mem[raddr2];

  // Reference model state.
  bit            m_last_lsu;
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [W-1:0]  m_wdata;
  logic [N-1:0]  m_busy;
  logic [W-1:0]  m_mem [N];
  bit            acc_alu, acc_lsu;
  logic          obs_wen;
  logic [W-1:0]  obs_rdata2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_lsu = 1'b1;
    m_wen      = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
    m_busy     = '0;
    acc_alu    = 1'b0;
    acc_lsu    = 1'b0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
  endtask

  function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
`ifdef REGFILE_WB_ARB_FWD_EN
    if (m_wen && m_waddr == a && a != '0) return m_wdata;
`endif
    return (a == '0) ? '0 : m_mem[a];
  endfunction

  // One clock cycle: called just after a rising edge with inputs already set.
  task automatic tick();
    bit            ga, gl, both;
    logic [AW-1:0] wrd;
    logic [W-1:0]  wdat;
    logic [N-1:0]  nb;
    @(negedge clk);
    both = alu_valid && lsu_valid;
    ga   = alu_valid && (!lsu_valid || m_last_lsu);
    gl   = lsu_valid && (!alu_valid || !m_last_lsu);
    chk("alu_ready", alu_ready, ga);
    chk("lsu_ready", lsu_ready, gl);
    chk("rf_wen",    rf_wen,    m_wen);
    chk("rf_waddr",  rf_waddr,  m_waddr);
    chk("rf_wdata",  rf_wdata,  m_wdata);
    chk("busy",      busy,      m_busy);
    chk("rdata1",    rdata1,    exp_read(raddr1));
    chk("rdata2",    rdata2,    exp_read(raddr2));
    obs_wen    = rf_wen;
    obs_rdata2 = rdata2;
    wrd  = ga ? alu_rd : lsu_rd;
    wdat = ga ? alu_data : lsu_data;
    nb   = m_busy;
    if (m_wen) nb[m_waddr] = 1'b0;
    if (iss_valid) nb[iss_rd] = 1'b1;
    nb[0] = 1'b0;
    @(posedge clk);
    if (m_wen) m_mem[m_waddr] = m_wdata;
    if (both) m_last_lsu = gl;
    m_wen = (ga || gl) && (wrd != '0);
    if (ga || gl) begin
      m_waddr = wrd;
      m_wdata = wdat;
    end
    m_busy  = nb;
    acc_alu = ga;
    acc_lsu = gl;
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    iss_valid = 1'b0;
  endtask

  // A request that lost arbitration is held unchanged until accepted.
  task automatic drive_random();
    if (!(alu_valid && !acc_alu)) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd    = AW'($urandom_range(0, 9));
      alu_data  = $urandom;
    end
    if (!(lsu_valid && !acc_lsu)) begin
      lsu_valid = 1'($urandom_range(0, 1));
      lsu_rd    = AW'($urandom_range(0, 9));
      lsu_data  = $urandom;
    end
    iss_valid = 1'($urandom_range(0, 1));
    iss_rd    = AW'($urandom_range(0, 9));
    raddr1    = AW'($urandom_range(0, 9));
    raddr2    = AW'($urandom_range(0, 9));
  endtask

  initial begin
    logic [W-1:0] pre7;
    logic [W-1:0] exp_fwd;
    rst_n = 1'b0;
    idle_inputs();
    alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
    iss_rd = '0; raddr1 = '0; raddr2 = '0;
    model_reset();
    #1;
    chk("reset_wen",   rf_wen,   1'b0);
    chk("reset_waddr", rf_waddr, '0);
    chk("reset_wdata", rf_wdata, '0);
    chk("reset_busy",  busy,     '0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single source write and read-back two cycles later.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA5A5A5A5;
    tick();
    chk("single_ready", acc_alu, 1'b1);
    alu_valid = 1'b0;
    tick();
    chk("single_wen",   obs_wen,  1'b1);
    chk("single_waddr", rf_waddr, 5'd1);
    chk("single_wdata", rf_wdata, 32'hA5A5A5A5);
    raddr1 = 5'd1;
    tick();
    chk("single_rdata", rdata1, 32'hA5A5A5A5);

    // Contention: both sources stay valid with fresh requests after each win.
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h5A5A5A5A;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_alu_grant", acc_alu, (k % 2) == 0);
      chk("tie_lsu_grant", acc_lsu, (k % 2) == 1);
      if (acc_alu) begin alu_rd = alu_rd + 5'd2; alu_data = alu_data + 32'd1; end
      if (acc_lsu) begin lsu_rd = lsu_rd + 5'd2; lsu_data = lsu_data + 32'd1; end
    end
    idle_inputs();
    repeat (2) tick();

    // Write to x0 is accepted but never commits.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
    tick();
    chk("x0_ready", acc_lsu, 1'b1);
    lsu_valid = 1'b0;
    tick();
    chk("x0_wen", obs_wen, 1'b0);

    // Scoreboard set, clear on commit, and set winning over clear.
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    chk("sb_set", busy[5], 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h00000055;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("sb_clear", busy[5], 1'b0);
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h00000066;
    tick();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    chk("sb_set_wins", busy[5], 1'b1);

    // Read of a register during its commit cycle.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0; raddr2 = 5'd7;
    pre7 = m_mem[7];
`ifdef REGFILE_WB_ARB_FWD_EN
    exp_fwd = 32'hDEADBEEF;
`else
    exp_fwd = pre7;
`endif
    tick();
    chk("fwd_rdata2", obs_rdata2, exp_fwd);

    // Reset with a write registered but not yet committed.
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h11111111;
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    chk("pre_rst_wen",  rf_wen,  1'b1);
    chk("pre_rst_busy", busy[4], 1'b1);
    #1 rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_wen",  rf_wen, 1'b0);
    chk("midrst_busy", busy,   '0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66666666;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88888888;
    tick();
    chk("post_rst_tie", acc_alu, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
